// File: rtl/axi4_boot_sequencer.sv
// axi4_boot_sequencer: passive AXI4 write-channel snooper that boots a core
// after a DMA image load. All AXI ports are inputs; nothing is driven back.
// Handshake semantics: an AW or W transfer happens on a rising aclk edge where
// the matching valid and ready are both high; this block only observes them.
// Optional feature: define BOOT_WDT_EN to add a RUN-state watchdog that halts
// the core after TIMEOUT_CYCLES RUN cycles without core_done_i.
module axi4_boot_sequencer #(
  parameter int                    DATA_WIDTH     = 512,
  parameter int                    ADDR_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0] DOORBELL_ADDR  = '0,
  parameter logic [63:0]           START_MAGIC    = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [63:0]           STOP_MAGIC     = 64'hDEAD_DEAD_DEAD_DEAD,
  parameter int                    PULSE_CYCLES   = 100,
  parameter int                    AW_DEPTH       = 4,
  parameter int                    TIMEOUT_CYCLES = 1000000
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  input  logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  input  logic                  s_axi_wready,
  input  logic                  s_axi_wlast,
  input  logic                  core_done_i,
  output logic                  core_rst_n_o,
  output logic                  start_o,
  output logic [1:0]            state_o,
  output logic [31:0]           beat_count_o,
  output logic [1:0]            err_o
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int PW  = $clog2(AW_DEPTH);
  localparam int PCW = $clog2(PULSE_CYCLES + 1);

  state_t state, state_n;

  // AW tracking FIFO: one bit per outstanding burst, set when it targets the doorbell
  logic [AW_DEPTH-1:0] fifo_q;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         occ;

  logic aw_hs, w_hs, fifo_empty, fifo_full, push, pop, db_beat;
  logic start_db, stop_db, err_aw_set;
  logic err_aw, err_wdt, wdt_expire;
  logic [PCW-1:0] pulse_cnt;
  logic [31:0]    beat_cnt;

  assign aw_hs      = s_axi_awvalid & s_axi_awready;
  assign w_hs       = s_axi_wvalid & s_axi_wready;
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == (PW + 1)'(AW_DEPTH));
  // A pop frees a slot in the same cycle, so push-while-full is legal with a pop
  assign pop        = w_hs & s_axi_wlast & ~fifo_empty;
  assign push       = aw_hs & (~fifo_full | pop);
  // Beats with no tracked burst are treated as ordinary data beats
  assign db_beat    = w_hs & ~fifo_empty & fifo_q[rd_ptr];
  assign start_db   = db_beat & (s_axi_wdata[63:0] == START_MAGIC);
  assign stop_db    = db_beat & (s_axi_wdata[63:0] == STOP_MAGIC);
  assign err_aw_set = (aw_hs & fifo_full & ~pop) | (w_hs & fifo_empty);

  generate
    if (DATA_WIDTH > 64) begin : g_wide
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^s_axi_wdata[DATA_WIDTH-1:64];
    end
  endgenerate

  // FIFO pointers, occupancy and stored doorbell flags
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      fifo_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= (s_axi_awaddr == DOORBELL_ADDR);
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Sticky AW tracking error; cleared only by reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_aw <= 1'b0;
    end else if (err_aw_set) begin
      err_aw <= 1'b1;
    end
  end

  // Start pulse length: holds PULSE_CYCLES outside START, counts down inside it
  always_ff @(posedge aclk) begin
    if (!aresetn || state != ST_START) begin
      pulse_cnt <= PCW'(PULSE_CYCLES);
    end else begin
      pulse_cnt <= pulse_cnt - 1'b1;
    end
  end

`ifdef BOOT_WDT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdt_cnt;

  // Watchdog: counts RUN cycles, restarts from zero every time RUN is entered
  always_ff @(posedge aclk) begin
    if (!aresetn || state != ST_RUN) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  assign wdt_expire = (state == ST_RUN) && (wdt_cnt == WW'(TIMEOUT_CYCLES - 1)) && !core_done_i;

  // Sticky watchdog error; cleared only by reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_wdt <= 1'b0;
    end else if (wdt_expire) begin
      err_wdt <= 1'b1;
    end
  end
`else
  localparam int wdt_limit_unused = TIMEOUT_CYCLES;
  assign wdt_expire = 1'b0;
  assign err_wdt    = 1'b0;
`endif

  // Load beat counter: counts non-doorbell beats in LOAD, cleared on HALT exit
  always_ff @(posedge aclk) begin
    if (!aresetn || state == ST_HALT) begin
      beat_cnt <= '0;
    end else if (state == ST_LOAD && w_hs && !db_beat && beat_cnt != 32'hFFFF_FFFF) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_LOAD;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      ST_LOAD: begin
        if (start_db) state_n = ST_START;
      end
      ST_START: begin
        if (stop_db)                       state_n = ST_HALT;
        else if (pulse_cnt == PCW'(1))     state_n = ST_RUN;
      end
      ST_RUN: begin
        if (core_done_i || stop_db || wdt_expire) state_n = ST_HALT;
      end
      ST_HALT: begin
        state_n = ST_LOAD;
      end
      default: state_n = ST_LOAD;
    endcase
  end

  assign core_rst_n_o = (state == ST_START) || (state == ST_RUN);
  assign start_o      = (state == ST_START);
  assign state_o      = state;
  assign beat_count_o = beat_cnt;
  assign err_o        = {err_wdt, err_aw};

endmodule

// File: tb/tb_axi4_boot_sequencer.sv
// Testbench for axi4_boot_sequencer: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the boot sequencer.
module tb_axi4_boot_sequencer;

  localparam int          DW      = 512;
  localparam int          AW      = 64;
  localparam int          PULSE   = 100;
  localparam int          DEPTH   = 4;
  localparam int          TIMEOUT = 50;
  localparam logic [63:0] START_M = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] STOP_M  = 64'hDEAD_DEAD_DEAD_DEAD;
  localparam logic [63:0] DB      = 64'h0;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] awaddr;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic          wvalid, wready, wlast;
  logic          core_done;
  logic          core_rst_n, start;
  logic [1:0]    state, err;
  logic [31:0]   beat_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: mode 0 LOAD, 1 START, 2 RUN, 3 HALT
  int          m_mode = 0;
  bit          m_db_q[$];
  logic [31:0] m_beats = '0;
  logic [1:0]  m_err = '0;
  int          m_pulse_left = 0;
  int          m_run = 0;

  axi4_boot_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DOORBELL_ADDR(DB),
    .START_MAGIC(START_M), .STOP_MAGIC(STOP_M), .PULSE_CYCLES(PULSE),
    .AW_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wlast(wlast),
    .core_done_i(core_done), .core_rst_n_o(core_rst_n), .start_o(start),
    .state_o(state), .beat_count_o(beat_count), .err_o(err)
  );

  // Clock and global time limit
  always #5 aclk = ~aclk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Applies the sequencer rules to the inputs seen at one rising edge
  task automatic model_clock();
    bit aw_hs, w_hs, is_db, pop;
    logic [63:0] wd;
    if (!aresetn) begin
      m_mode = 0; m_db_q.delete(); m_beats = '0; m_err = '0; m_pulse_left = 0; m_run = 0;
      return;
    end
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    wd    = wdata[63:0];
    is_db = w_hs && (m_db_q.size() > 0) && m_db_q[0];
    if (w_hs && m_db_q.size() == 0) m_err[0] = 1'b1;
    case (m_mode)
      0: begin
        if (is_db && wd == START_M) begin
          m_mode = 1; m_pulse_left = PULSE;
        end else if (w_hs && !is_db && m_beats != 32'hFFFF_FFFF) begin
          m_beats = m_beats + 1;
        end
      end
      1: begin
        if (is_db && wd == STOP_M) m_mode = 3;
        else begin
          m_pulse_left--;
          if (m_pulse_left == 0) begin m_mode = 2; m_run = 0; end
        end
      end
      2: begin
        if (core_done) m_mode = 3;
        else begin
`ifdef BOOT_WDT_EN
          m_run++;
          if (m_run >= TIMEOUT) begin m_mode = 3; m_err[1] = 1'b1; end
          else if (is_db && wd == STOP_M) m_mode = 3;
`else
          if (is_db && wd == STOP_M) m_mode = 3;
`endif
        end
      end
      default: begin m_mode = 0; m_beats = '0; end
    endcase
    pop = w_hs && wlast && (m_db_q.size() > 0);
    if (pop) void'(m_db_q.pop_front());
    if (aw_hs) begin
      if (m_db_q.size() < DEPTH) m_db_q.push_back(awaddr == DB);
      else m_err[0] = 1'b1;
    end
  endtask

  function automatic logic [37:0] model_out();
    logic [1:0] ms;
    ms = 2'(m_mode);
    return {ms, (m_mode == 1 || m_mode == 2), (m_mode == 1), m_err, m_beats};
  endfunction

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge aclk);
    model_clock();
    @(negedge aclk);
  endtask

  task automatic do_aw(input logic [63:0] addr);
    awaddr = addr; awvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      awready = (i == 7) || ($urandom_range(0, 3) != 0);
      tick();
      if (awready) break;
    end
    awvalid = 1'b0; awready = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] lo, input bit last);
    wdata = rand_wide(); wdata[63:0] = lo; wlast = last; wvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wready = (i == 7) || ($urandom_range(0, 3) != 0);
      tick();
      if (wready) break;
    end
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; tick(); aresetn = 1'b1; tick();
  endtask

  task automatic wait_mode(input int target, input int budget);
    for (int i = 0; i < budget && m_mode != target; i++) tick();
  endtask

  // Drives core_done in RUN until the model is back in LOAD
  task automatic go_load();
    for (int i = 0; i < 500 && m_mode != 0; i++) begin
      core_done = (m_mode == 2);
      tick();
    end
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; tick(); tick();
    tests_run++;
    if ({state, core_rst_n, start, err, beat_count} !== 38'h0) begin
      tests_failed++;
      $display("FAIL reset_values: got %h required %h", {state, core_rst_n, start, err, beat_count}, 38'h0);
    end
    aresetn = 1'b1; tick();
    tests_run++;
    if ({state, core_rst_n, start, err, beat_count} !== model_out()) begin
      tests_failed++;
      $display("FAIL reset_release: got %h required %h", {state, core_rst_n, start, err, beat_count}, model_out());
    end
  endtask

  task automatic test_boot();
    int cnt;
    for (int i = 0; i < 8; i++) begin
      do_aw(64'h1000); do_w({$urandom, $urandom}, 1'b1);
    end
    tests_run++;
    if (beat_count !== 32'd8 || start !== 1'b0) begin
      tests_failed++;
      $display("FAIL boot_load_count: got beats=%0d start=%b required beats=8 start=0", beat_count, start);
    end
    do_aw(DB); do_w(START_M, 1'b1);
    tests_run++;
    if (state !== 2'd1 || start !== 1'b1 || core_rst_n !== 1'b1 || beat_count !== 32'd8) begin
      tests_failed++;
      $display("FAIL boot_start_edge: got state=%0d start=%b rst_n=%b beats=%0d required 1 1 1 8",
               state, start, core_rst_n, beat_count);
    end
    cnt = 0;
    while (start === 1'b1 && cnt < 400) begin cnt++; tick(); end
    tests_run++;
    if (cnt != PULSE) begin
      tests_failed++;
      $display("FAIL boot_pulse_len: got %0d cycles required %0d", cnt, PULSE);
    end
    tests_run++;
    if ({state, core_rst_n, start, err, beat_count} !== model_out() || state !== 2'd2) begin
      tests_failed++;
      $display("FAIL boot_run: got %h required %h", {state, core_rst_n, start, err, beat_count}, model_out());
    end
  endtask

  task automatic test_done();
    core_done = 1'b1; tick(); core_done = 1'b0;
    tests_run++;
    if (state !== 2'd3 || core_rst_n !== 1'b0 || start !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_halt: got state=%0d rst_n=%b start=%b required 3 0 0", state, core_rst_n, start);
    end
    tick();
    tests_run++;
    if (state !== 2'd0 || beat_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL done_reload: got state=%0d beats=%0d required 0 0", state, beat_count);
    end
    do_aw(DB); do_w(START_M, 1'b1);
    tests_run++;
    if ({state, core_rst_n, start, err, beat_count} !== model_out() || start !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_reboot: got %h required %h", {state, core_rst_n, start, err, beat_count}, model_out());
    end
    go_load();
  endtask

  task automatic test_multi_aw();
    do_aw(64'h40); do_aw(DB); do_aw(64'h80);
    do_w({$urandom, $urandom}, 1'b0); do_w({$urandom, $urandom}, 1'b1);
    do_w(START_M, 1'b0);
    tests_run++;
    if (state !== 2'd1) begin
      tests_failed++;
      $display("FAIL multi_aw_start: got state=%0d required 1", state);
    end
    do_w(START_M, 1'b1);
    do_w({$urandom, $urandom}, 1'b0); do_w({$urandom, $urandom}, 1'b1);
    // Only the 0x40 burst lands before the doorbell; later beats are outside LOAD
    tests_run++;
    if ({state, core_rst_n, start, err, beat_count} !== model_out() || beat_count !== 32'd2) begin
      tests_failed++;
      $display("FAIL multi_aw_count: got %h required %h", {state, core_rst_n, start, err, beat_count}, model_out());
    end
    go_load();
  endtask

  task automatic test_stop();
    do_aw(DB); do_w(START_M, 1'b1);
    do_aw(DB);
    for (int i = 0; i < 200 && m_pulse_left > PULSE - 19; i++) tick();
    do_w(STOP_M, 1'b1);
    tests_run++;
    if ({state, core_rst_n, start, err, beat_count} !== model_out() || state !== 2'd3 || start !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_in_start: got %h required %h", {state, core_rst_n, start, err, beat_count}, model_out());
    end
    tick();
    do_aw(DB); do_w(START_M, 1'b1);
    wait_mode(2, 300);
    do_aw(DB); do_w(START_M, 1'b1);
    tests_run++;
    if (state !== 2'd2 || start !== 1'b0 || core_rst_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_in_run_ignored: got state=%0d start=%b rst_n=%b required 2 0 1", state, start, core_rst_n);
    end
    do_aw(DB); do_w(STOP_M, 1'b1);
    tests_run++;
    if ({state, core_rst_n, start, err, beat_count} !== model_out() || state !== 2'd3) begin
      tests_failed++;
      $display("FAIL stop_in_run: got %h required %h", {state, core_rst_n, start, err, beat_count}, model_out());
    end
    tick();
  endtask

  task automatic test_push_pop_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_aw(64'h3000);
    awaddr = DB; awvalid = 1'b1; awready = 1'b1;
    wdata = rand_wide(); wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    tick();
    awvalid = 1'b0; awready = 1'b0; wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) do_w({$urandom, $urandom}, 1'b1);
    do_w(START_M, 1'b1);
    tests_run++;
    if ({state, core_rst_n, start, err, beat_count} !== {2'd1, 1'b1, 1'b1, 2'b00, 32'd4} ||
        {state, core_rst_n, start, err, beat_count} !== model_out()) begin
      tests_failed++;
      $display("FAIL push_pop_full: got %h required %h", {state, core_rst_n, start, err, beat_count}, model_out());
    end
    go_load();
  endtask

  task automatic test_aw_err();
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_aw(64'h2000 + 64'(i));
    tests_run++;
    if (err !== 2'b00) begin
      tests_failed++;
      $display("FAIL aw_err_not_full: got err=%b required 00", err);
    end
    do_aw(64'h2100);
    tests_run++;
    if (err !== 2'b01 || err !== model_out()[33:32]) begin
      tests_failed++;
      $display("FAIL aw_err_overflow: got err=%b required 01", err);
    end
    do_reset();
    do_w({$urandom, $urandom}, 1'b1);
    tests_run++;
    if ({state, core_rst_n, start, err, beat_count} !== model_out() || err !== 2'b01) begin
      tests_failed++;
      $display("FAIL aw_err_orphan_w: got %h required %h", {state, core_rst_n, start, err, beat_count}, model_out());
    end
  endtask

  task automatic test_reset_mid_start();
    do_reset();
    do_aw(DB); do_w(START_M, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    aresetn = 1'b0; tick();
    tests_run++;
    if ({state, core_rst_n, start, err, beat_count} !== 38'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_start: got %h required %h", {state, core_rst_n, start, err, beat_count}, 38'h0);
    end
    aresetn = 1'b1; tick();
  endtask

  task automatic test_random();
    logic [63:0] addr, lo;
    int beats;
    for (int t = 0; t < 60; t++) begin
      addr  = ($urandom_range(0, 3) == 0) ? DB : ({$urandom, $urandom} | 64'h1000);
      beats = $urandom_range(1, 3);
      core_done = ($urandom_range(0, 7) == 0);
      do_aw(addr);
      for (int b = 0; b < beats; b++) begin
        case ($urandom_range(0, 3))
          0:       lo = START_M;
          1:       lo = STOP_M;
          default: lo = {$urandom, $urandom};
        endcase
        do_w(lo, b == beats - 1);
      end
      core_done = 1'b0;
      for (int k = $urandom_range(0, 3); k > 0; k--) tick();
      tests_run++;
      if ({state, core_rst_n, start, err, beat_count} !== model_out()) begin
        tests_failed++;
        $display("FAIL random_txn_%0d: got %h required %h", t, {state, core_rst_n, start, err, beat_count}, model_out());
      end
    end
    go_load();
  endtask

`ifdef BOOT_WDT_EN
  task automatic test_watchdog();
    int cnt;
    do_reset();
    do_aw(DB); do_w(START_M, 1'b1);
    wait_mode(2, 300);
    cnt = 0;
    while (state === 2'd2 && cnt < 200) begin cnt++; tick(); end
    tests_run++;
    if (cnt != TIMEOUT || state !== 2'd3 || err !== 2'b10) begin
      tests_failed++;
      $display("FAIL watchdog: got run=%0d state=%0d err=%b required %0d 3 10", cnt, state, err, TIMEOUT);
    end
    tick();
  endtask
`endif

  initial begin
    aresetn = 1'b0; awaddr = '0; awvalid = 1'b0; awready = 1'b0;
    wdata = '0; wvalid = 1'b0; wready = 1'b0; wlast = 1'b0; core_done = 1'b0;
    @(negedge aclk);
    test_reset();
    test_boot();
    test_done();
    test_multi_aw();
    test_stop();
    test_push_pop_full();
    test_aw_err();
    test_reset_mid_start();
    test_random();
`ifdef BOOT_WDT_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
